buzzer_tune_fetch: RTL

//   Read-side engine for the buzzer tune bus. Serves word requests from the buzzer

---
 rtl/buzzer_tune_fetch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/buzzer_tune_fetch.sv
// ----------------------------------------------------------------------------
// buzzer_tune_fetch
//   Read-side engine for the buzzer tune bus. It serves word requests from the
//   buzzer sequencer. For each request it computes a tune-memory address, issues
//   one read on the memory bus and holds the returned word on buf_data with ready
//   set until the sequencer consumes it. If the memory does not answer within
//   TIMEOUT cycles, the engine returns a 0x0000 end-of-tune word instead.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                pulse: latch cfg_base, then read the first word
//   abort                synchronous clear, highest priority
//   cfg_base [AW]        tune base address, sampled when start is accepted
//   addr_sel             0: word at base; 1: word at base+1+addr_off
//   addr_off [AW]        note index from the sequencer address counter
//   fetch                pulse: consume the held word and read the next one
//   buf_data [DW]        held tune word, valid while ready=1
//   ready                buf_data valid
//   err                  sticky timeout flag
//   mem_req              read request, held until mem_ack
//   mem_addr [AW]        read address, stable while mem_req=1
//   mem_ack, mem_rdata   single-cycle response strobe and its data
// ----------------------------------------------------------------------------
module buzzer_tune_fetch #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] cfg_base,
    input  logic          addr_sel,
    input  logic [AW-1:0] addr_off,
    input  logic          fetch,
    output logic [DW-1:0] buf_data,
    output logic          ready,
    output logic          err,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    // Count value seen in the last cycle of the wait window: mem_req is then
    // high for exactly TIMEOUT cycles before the timeout takes effect.
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StDrain
    } state_e;

    state_e        state;
    logic [AW-1:0] base;
    logic [15:0]   tcount;

    // Address arithmetic wraps modulo 2^AW.
    function automatic logic [AW-1:0] calc_addr(input logic [AW-1:0] b,
                                                input logic          sel,
                                                input logic [AW-1:0] off);
        logic [AW-1:0] one;
        one = AW'(1);
        return sel ? (b + one + off) : b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            buf_data <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            base     <= '0;
            tcount   <= '0;
        end else if (abort) begin
            ready <= 1'b0;
            err   <= 1'b0;
            // A read still in flight must be retired on the bus before the
            // engine may return to idle. If it completes or times out in this
            // very cycle there is nothing left to drain.
            if (state == StReq && !mem_ack && tcount != ToLast) begin
                state  <= StDrain;
                tcount <= tcount + 16'd1;
            end else begin
                state   <= StIdle;
                mem_req <= 1'b0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        base     <= cfg_base;
                        mem_addr <= calc_addr(cfg_base, addr_sel, addr_off);
                        mem_req  <= 1'b1;
                        err      <= 1'b0;
                        tcount   <= '0;
                        state    <= StReq;
                    end
                end

                StReq: begin
                    if (mem_ack) begin
                        buf_data <= mem_rdata;
                        ready    <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= StHold;
                    end else if (tcount == ToLast) begin
                        // No response: hand back an end-of-tune word.
                        buf_data <= '0;
                        ready    <= 1'b1;
                        err      <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= StHold;
                    end else begin
                        tcount <= tcount + 16'd1;
                    end
                end

                StHold: begin
                    if (start) begin
                        base     <= cfg_base;
                        mem_addr <= calc_addr(cfg_base, addr_sel, addr_off);
                        err      <= 1'b0;
                        ready    <= 1'b0;
                        mem_req  <= 1'b1;
                        tcount   <= '0;
                        state    <= StReq;
                    end else if (fetch) begin
                        mem_addr <= calc_addr(base, addr_sel, addr_off);
                        ready    <= 1'b0;
                        mem_req  <= 1'b1;
                        tcount   <= '0;
                        state    <= StReq;
                    end
                end

                StDrain: begin
                    // Returned data is discarded; err is left as it is.
                    if (mem_ack || tcount == ToLast) begin
                        mem_req <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        tcount <= tcount + 16'd1;
                    end
                end

                default: begin
                    state   <= StIdle;
                    mem_req <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
